// File: rtl/and_cell_sequencer_if.sv
// Request/response handshake bundle between a requester and the AND-cell sequencer.
interface and_cell_sequencer_if;
  logic req_valid;
  logic req_ready;
  logic req_a;
  logic req_b;
  logic rsp_valid;
  logic rsp_ready;
  logic rsp_out;
  logic rsp_err;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_out, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_out, rsp_err
  );
endinterface

// File: rtl/and_cell_sequencer.sv
// Drives one AND cell through setup / clock-high / hold phases per operand pair
// and reports the captured output together with a mismatch flag and count.
module and_cell_sequencer #(
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned HIGH_CYC  = 1,
  parameter int unsigned HOLD_CYC  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  and_cell_sequencer_if.slave  bus,
  output logic                 dut_a,
  output logic                 dut_b,
  output logic                 dut_clk,
  input  logic                 dut_out,
  output logic [7:0]           err_cnt,
  output logic                 busy
);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, HOLD, RESP} state_e;

  localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
  localparam logic [3:0] HIGH_LD  = 4'(HIGH_CYC - 1);
  localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYC - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       dut_a_q, dut_a_d;
  logic       dut_b_q, dut_b_d;
  logic       dut_clk_q, dut_clk_d;
  logic       exp_ab_q, exp_ab_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic       rsp_out_q, rsp_out_d;
  logic       rsp_err_q, rsp_err_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       busy_q, busy_d;
  logic       req_ready_q, req_ready_d;

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case infers a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    dut_a_d     = dut_a_q;
    dut_b_d     = dut_b_q;
    dut_clk_d   = dut_clk_q;
    exp_ab_d    = exp_ab_q;
    rsp_valid_d = rsp_valid_q;
    rsp_out_d   = rsp_out_q;
    rsp_err_d   = rsp_err_q;
    err_cnt_d   = err_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          state_d  = SETUP;
          cnt_d    = SETUP_LD;
          dut_a_d  = bus.req_a;
          dut_b_d  = bus.req_b;
          exp_ab_d = bus.req_a & bus.req_b;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d   = HIGH;
          cnt_d     = HIGH_LD;
          dut_clk_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HIGH: begin
        if (cnt_q == '0) begin
          state_d   = HOLD;
          cnt_d     = HOLD_LD;
          dut_clk_d = 1'b0;
          rsp_out_d = dut_out;
          rsp_err_d = (dut_out != exp_ab_q);
          // Saturate rather than wrap so a long failing run still reads as "many".
          if ((dut_out != exp_ab_q) && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Status outputs are registered copies of the next state.
    busy_d      = (state_d != IDLE);
    req_ready_d = (state_d == IDLE);
  end

  // NOTE: state uses non-blocking assignments and an async active-low reset in the sensitivity list.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dut_a_q     <= 1'b0;
      dut_b_q     <= 1'b0;
      dut_clk_q   <= 1'b0;
      exp_ab_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_out_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      err_cnt_q   <= '0;
      busy_q      <= 1'b0;
      req_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dut_a_q     <= dut_a_d;
      dut_b_q     <= dut_b_d;
      dut_clk_q   <= dut_clk_d;
      exp_ab_q    <= exp_ab_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_out_q   <= rsp_out_d;
      rsp_err_q   <= rsp_err_d;
      err_cnt_q   <= err_cnt_d;
      busy_q      <= busy_d;
      req_ready_q <= req_ready_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_out   = rsp_out_q;
  assign bus.rsp_err   = rsp_err_q;
  assign dut_a         = dut_a_q;
  assign dut_b         = dut_b_q;
  assign dut_clk       = dut_clk_q;
  assign err_cnt       = err_cnt_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_and_cell_sequencer.sv
// Bench for and_cell_sequencer: three instances (2,1,1), (1,1,1), (15,15,15), each
// driving a behavioural AND-cell model that can be correct, stuck at 0 or inverted.
module tb_and_cell_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       req_valid_v [3];
  logic       req_a_v     [3];
  logic       req_b_v     [3];
  logic       rsp_ready_v [3];
  logic       req_ready_v [3];
  logic       rsp_valid_v [3];
  logic       rsp_out_v   [3];
  logic       rsp_err_v   [3];
  logic       dut_a_v     [3];
  logic       dut_b_v     [3];
  logic       dut_clk_v   [3];
  logic       dut_out_v   [3];
  logic       busy_v      [3];
  logic [7:0] err_cnt_v   [3];
  int         mode_v      [3];   // 0 correct, 1 stuck at 0, 2 inverted

  int checks = 0;
  int errors = 0;
  int exp_cnt [3];

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int S  = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
    localparam int H  = (g == 0) ? 1 : ((g == 1) ? 1 : 15);
    localparam int HO = (g == 0) ? 1 : ((g == 1) ? 1 : 15);

    and_cell_sequencer_if bus ();
    logic model_q = 1'b0;

    assign bus.req_valid = req_valid_v[g];
    assign bus.req_a     = req_a_v[g];
    assign bus.req_b     = req_b_v[g];
    assign bus.rsp_ready = rsp_ready_v[g];
    assign req_ready_v[g] = bus.req_ready;
    assign rsp_valid_v[g] = bus.rsp_valid;
    assign rsp_out_v[g]   = bus.rsp_out;
    assign rsp_err_v[g]   = bus.rsp_err;
    assign dut_out_v[g]   = model_q;

    always @(posedge dut_clk_v[g]) begin
      case (mode_v[g])
        0:       model_q <= dut_a_v[g] & dut_b_v[g];
        1:       model_q <= 1'b0;
        default: model_q <= ~(dut_a_v[g] & dut_b_v[g]);
      endcase
    end

    and_cell_sequencer #(.SETUP_CYC(S), .HIGH_CYC(H), .HOLD_CYC(HO)) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus.slave),
      .dut_a   (dut_a_v[g]),
      .dut_b   (dut_b_v[g]),
      .dut_clk (dut_clk_v[g]),
      .dut_out (dut_out_v[g]),
      .err_cnt (err_cnt_v[g]),
      .busy    (busy_v[g])
    );
  end

  function automatic int p_setup(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 15);
  endfunction
  function automatic int p_high(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 1 : 15);
  endfunction
  function automatic int p_hold(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 1 : 15);
  endfunction

  // One complete transaction on instance k, checked against timing and value rules.
  task automatic do_op(input int k, input logic a, input logic b, input int wait_resp);
    int   s, h, ho, first_hi, hi_cnt, first_v;
    logic exp_out, exp_err, ok;
    s  = p_setup(k);
    h  = p_high(k);
    ho = p_hold(k);
    exp_out = (mode_v[k] == 0) ? (a & b) : ((mode_v[k] == 1) ? 1'b0 : ~(a & b));
    exp_err = (exp_out != (a & b));
    if (exp_err && exp_cnt[k] < 255) exp_cnt[k]++;

    @(negedge clk);
    checks++;
    if (req_ready_v[k] !== 1'b1) begin
      errors++;
      $display("FAIL op_ready[%0d]: req_ready=%b expected 1", k, req_ready_v[k]);
    end
    req_valid_v[k] = 1'b1;
    req_a_v[k]     = a;
    req_b_v[k]     = b;
    rsp_ready_v[k] = 1'b0;
    @(posedge clk);

    first_hi = -1;
    hi_cnt   = 0;
    first_v  = -1;
    ok       = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (dut_a_v[k] !== a || dut_b_v[k] !== b) ok = 1'b0;
      if (rsp_valid_v[k] === 1'b1) begin
        first_v = i;
        break;
      end
      if (dut_clk_v[k] === 1'b1) begin
        if (first_hi < 0) first_hi = i;
        hi_cnt++;
      end
      if (busy_v[k] !== 1'b1 || req_ready_v[k] !== 1'b0) ok = 1'b0;
      req_valid_v[k] = 1'($urandom);
      req_a_v[k]     = 1'($urandom);
      req_b_v[k]     = 1'($urandom);
      rsp_ready_v[k] = 1'($urandom);
    end
    rsp_ready_v[k] = 1'b0;

    checks++;
    if (first_v != s + h + ho) begin
      errors++;
      $display("FAIL latency[%0d]: rsp_valid at %0d expected %0d", k, first_v, s + h + ho);
    end
    checks++;
    if (first_hi != s) begin
      errors++;
      $display("FAIL setup_len[%0d]: dut_clk rose at %0d expected %0d", k, first_hi, s);
    end
    checks++;
    if (hi_cnt != h) begin
      errors++;
      $display("FAIL high_len[%0d]: %0d high cycles expected %0d", k, hi_cnt, h);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL in_flight[%0d]: operands/busy/ready disturbed, got 0 expected 1", k);
    end
    checks++;
    if (rsp_out_v[k] !== exp_out || rsp_err_v[k] !== exp_err) begin
      errors++;
      $display("FAIL result[%0d]: out/err=%b%b expected %b%b", k,
               rsp_out_v[k], rsp_err_v[k], exp_out, exp_err);
    end
    checks++;
    if (err_cnt_v[k] !== 8'(exp_cnt[k])) begin
      errors++;
      $display("FAIL err_cnt[%0d]: got %0d expected %0d", k, err_cnt_v[k], exp_cnt[k]);
    end

    if (wait_resp > 0) begin
      ok = 1'b1;
      for (int j = 0; j < wait_resp; j++) begin
        req_valid_v[k] = ~req_valid_v[k];
        req_a_v[k]     = ~req_a_v[k];
        req_b_v[k]     = 1'($urandom);
        @(negedge clk);
        if (rsp_valid_v[k] !== 1'b1 || rsp_out_v[k] !== exp_out || rsp_err_v[k] !== exp_err ||
            req_ready_v[k] !== 1'b0 || dut_a_v[k] !== a || dut_b_v[k] !== b) ok = 1'b0;
      end
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL backpressure[%0d]: response not held, got 0 expected 1", k);
      end
    end

    req_valid_v[k] = 1'b0;
    rsp_ready_v[k] = 1'b1;
    @(negedge clk);
    rsp_ready_v[k] = 1'b0;
    checks++;
    if (rsp_valid_v[k] !== 1'b0 || req_ready_v[k] !== 1'b1 || busy_v[k] !== 1'b0 ||
        dut_a_v[k] !== a || dut_b_v[k] !== b) begin
      errors++;
      $display("FAIL release[%0d]: valid/ready/busy/a/b=%b%b%b%b%b expected 01%b%b%b", k,
               rsp_valid_v[k], req_ready_v[k], busy_v[k], dut_a_v[k], dut_b_v[k], 1'b0, a, b);
    end
  endtask

  task automatic test_reset;
    for (int k = 0; k < 3; k++) begin
      req_valid_v[k] = 1'($urandom);
      req_a_v[k]     = 1'($urandom);
      req_b_v[k]     = 1'($urandom);
      rsp_ready_v[k] = 1'($urandom);
    end
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({rsp_valid_v[k], rsp_out_v[k], rsp_err_v[k], dut_a_v[k], dut_b_v[k],
           dut_clk_v[k], busy_v[k], err_cnt_v[k]} !== 15'd0) begin
        errors++;
        $display("FAIL reset_outputs[%0d]: outputs not all zero before any clk edge, expected 0", k);
      end
      exp_cnt[k] = 0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      req_valid_v[k] = 1'b0;
      rsp_ready_v[k] = 1'b0;
    end
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (req_ready_v[k] !== 1'b1 || busy_v[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_release[%0d]: ready/busy=%b%b expected 10", k, req_ready_v[k], busy_v[k]);
      end
    end
  endtask

  task automatic test_basic;
    mode_v[0] = 0;
    do_op(0, 1'b1, 1'b1, 0);
  endtask

  task automatic test_backpressure;
    do_op(0, 1'($urandom), 1'($urandom), 5);
  endtask

  task automatic test_stuck;
    mode_v[0] = 1;
    do_op(0, 1'b1, 1'b1, 1);
    do_op(0, 1'b0, 1'b1, 0);
    mode_v[0] = 0;
  endtask

  task automatic test_reset_mid_op;
    int   n;
    logic seen;
    mode_v[0] = 2;
    @(negedge clk);
    req_valid_v[0] = 1'b1;
    req_a_v[0]     = 1'b1;
    req_b_v[0]     = 1'b1;
    @(negedge clk);
    req_valid_v[0] = 1'b0;
    n = 0;
    while (dut_clk_v[0] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (dut_clk_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_reach_high: dut_clk=%b expected 1", dut_clk_v[0]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (dut_clk_v[0] !== 1'b0 || busy_v[0] !== 1'b0 || rsp_valid_v[0] !== 1'b0 ||
        err_cnt_v[0] !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset_async: clk/busy/valid=%b%b%b cnt=%0d expected 000 cnt=0",
               dut_clk_v[0], busy_v[0], rsp_valid_v[0], err_cnt_v[0]);
    end
    for (int k = 0; k < 3; k++) exp_cnt[k] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid_v[0] !== 1'b0 || busy_v[0] !== 1'b0 || err_cnt_v[0] !== 8'd0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL mid_reset_dropped: stale response or count seen, got 1 expected 0");
    end
    mode_v[0] = 0;
    do_op(0, 1'b1, 1'b0, 0);
  endtask

  task automatic test_saturation;
    mode_v[1] = 2;
    repeat (260) do_op(1, 1'($urandom), 1'($urandom), 0);
    checks++;
    if (err_cnt_v[1] !== 8'd255) begin
      errors++;
      $display("FAIL saturation: err_cnt=%0d expected 255", err_cnt_v[1]);
    end
    mode_v[1] = 0;
  endtask

  task automatic test_param_sweep;
    for (int r = 0; r < 4; r++) begin
      do_op(1, 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
      do_op(2, 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_random;
    for (int r = 0; r < 20; r++) begin
      mode_v[0] = int'($urandom_range(0, 2));
      do_op(0, 1'($urandom), 1'($urandom), int'($urandom_range(0, 4)));
    end
    mode_v[0] = 0;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      req_valid_v[k] = 1'b0;
      req_a_v[k]     = 1'b0;
      req_b_v[k]     = 1'b0;
      rsp_ready_v[k] = 1'b0;
      mode_v[k]      = 0;
      exp_cnt[k]     = 0;
    end
    test_reset();
    test_basic();
    test_backpressure();
    test_stuck();
    test_reset_mid_op();
    test_saturation();
    test_param_sweep();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/and_cell_sequencer.md
AND_CELL_SEQUENCER -- requirements
Module: and_cell_sequencer

Interface
REQ-001 Parameter SETUP_CYC, default 2: cycles dut_a/dut_b are stable with dut_clk low before dut_clk rises; legal 1..15.
REQ-002 Parameter HIGH_CYC, default 1: cycles dut_clk is high; legal 1..15.
REQ-003 Parameter HOLD_CYC, default 1: cycles dut_a/dut_b are held stable after dut_clk falls; legal 1..15.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 req_valid  input  1  operand pair offered.
REQ-007 req_ready  output  1  sequencer can accept an operand pair.
REQ-008 req_a, req_b  input  1 each  operands.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer accepts result.
REQ-011 rsp_out  output  1  captured DUT output.
REQ-012 rsp_err  output  1  captured output differs from req_a & req_b.
REQ-013 err_cnt  output  8  saturating count of mismatches.
REQ-014 dut_a, dut_b, dut_clk  output  1 each  registered drives to the AND cell under test.
REQ-015 dut_out  input  1  AND cell output.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states SHALL be IDLE, SETUP, HIGH, HOLD and RESP; every output SHALL be driven from a register.
REQ-018 req_ready SHALL be 1 only in IDLE; acceptance is req_valid & req_ready at a rising edge.
REQ-019 On acceptance: req_a/req_b latched into dut_a/dut_b and into internal expected operands; FSM -> SETUP; phase counter loaded with SETUP_CYC-1.
REQ-020 SETUP: dut_clk=0 for exactly SETUP_CYC cycles; when the counter reaches 0, FSM -> HIGH, counter loaded with HIGH_CYC-1, dut_clk=1 from the next cycle.
REQ-021 HIGH: dut_clk=1 for exactly HIGH_CYC cycles; on the edge that leaves HIGH, dut_out is captured into rsp_out, rsp_err is set to (dut_out != a&b), and the FSM moves to HOLD with counter = HOLD_CYC-1 and dut_clk=0.
REQ-022 HOLD: dut_clk=0 for exactly HOLD_CYC cycles, then FSM -> RESP.
REQ-023 dut_a/dut_b SHALL change only on acceptance; they are stable through SETUP, HIGH, HOLD and RESP and retain their values in IDLE.
REQ-024 RESP: rsp_valid=1; rsp_out and rsp_err are stable until rsp_valid & rsp_ready; on that edge rsp_valid -> 0 and FSM -> IDLE.
REQ-025 There is no bypass: after a response handshake, req_ready rises one cycle later; minimum period is SETUP_CYC+HIGH_CYC+HOLD_CYC+2 cycles per operation.
REQ-026 Latency: rsp_valid is first high in the cycle after edge E0+SETUP_CYC+HIGH_CYC+HOLD_CYC, where E0 is the acceptance edge.
REQ-027 err_cnt increments by 1 on each capture with a mismatch and saturates at 255 without wrapping.
REQ-028 req_valid asserted outside IDLE is ignored, with no state change; rsp_ready outside RESP is ignored.

Reset
REQ-029 While rst_n=0, the following are forced to 0 immediately, independent of clk: FSM=IDLE, counter=0, dut_a=dut_b=dut_clk=0, rsp_valid=rsp_out=rsp_err=0, err_cnt=0, busy=0. req_ready is 1 once reset is released.
REQ-030 Reset mid-operation SHALL abandon the operation: a pending response is dropped and no err_cnt update occurs.

Verification (defaults SETUP_CYC=2, HIGH_CYC=1, HOLD_CYC=1; AND-cell model registers a&b on rising dut_clk)
REQ-031 Assert rst_n=0 with random inputs -> all outputs 0 with no clk edge; after release, req_ready=1 and busy=0.
REQ-032 Accept a=1, b=1 at edge E0 with a correct model -> dut_clk high exactly in the cycle after E0+2; rsp_valid high after E0+4; rsp_out=1, rsp_err=0, err_cnt=0.
REQ-033 Hold rsp_ready=0 for 5 cycles in RESP and toggle req_valid/req_a -> rsp_valid and rsp_out stay stable, req_ready=0, dut_a/dut_b are unchanged; rsp_ready=1 -> IDLE, and req_ready=1 in the next cycle.
REQ-034 Model stuck at 0, request a=1, b=1 -> rsp_out=0, rsp_err=1, err_cnt=1; then request a=0, b=1 -> rsp_err=0, err_cnt stays 1.
REQ-035 Pulse rst_n low while dut_clk=1 (HIGH) -> dut_clk=0 and busy=0 immediately; no rsp_valid follows; the next request completes normally.
REQ-036 Run 260 mismatching operations -> err_cnt reaches 255 and holds at 255; sweep the parameters (1,1,1) and (15,15,15) -> phase lengths equal the parameter values.
